// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
// Widths, reset PC, bubble encoding and fetch FSM states.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0]    RESET_PC  = 8'h00;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: imem, BTB, branch resolution and IF/ID outputs.
// master = fetch stage, slave = surrounding core / bench.
interface fetch_stage_if #(
  parameter int CNT_W = 16
);
  import cpu_pkg::*;

  logic               stall;
  logic [INSTR_W-1:0] imem_rdata;
  logic               bp_taken;
  logic [PC_W-1:0]    bp_target;
  logic               branch_indicator;
  logic               branch;
  logic [PC_W-1:0]    pc_branch;

  logic [PC_W-1:0]    imem_addr;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    if_id_pc;
  logic [INSTR_W-1:0] if_id_instr;
  logic               if_id_valid;
  logic               if_id_pred_taken;
  logic [PC_W-1:0]    if_id_pred_target;
  logic               flush;
  logic [CNT_W-1:0]   mispredict_count;

  modport master (
    input  stall, imem_rdata, bp_taken, bp_target,
    input  branch_indicator, branch, pc_branch,
    output imem_addr, pc, if_id_pc, if_id_instr,
    output if_id_valid, if_id_pred_taken,
    output if_id_pred_target, flush, mispredict_count
  );

  modport slave (
    output stall, imem_rdata, bp_taken, bp_target,
    output branch_indicator, branch, pc_branch,
    input  imem_addr, pc, if_id_pc, if_id_instr,
    input  if_id_valid, if_id_pred_taken,
    input  if_id_pred_target, flush, mispredict_count
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Bubble beats stall; stall holds every field.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_bubble,
  input  logic               i_stall,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_pred_taken,
  input  logic [PC_W-1:0]    i_pred_target,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_valid,
  output logic               o_pred_taken,
  output logic [PC_W-1:0]    o_pred_target
);

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic               r_pred_taken;
  logic [PC_W-1:0]    r_pred_target;

  always_ff @(posedge clk) begin
    if (rst || i_bubble) begin
      r_pc          <= '0;
      r_instr       <= NOP_INSTR;
      r_valid       <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else if (!i_stall) begin
      r_pc          <= i_pc;
      r_instr       <= i_instr;
      r_valid       <= 1'b1;
      r_pred_taken  <= i_pred_taken;
      r_pred_target <= i_pred_target;
    end
  end

  assign o_pc          = r_pc;
  assign o_instr       = r_instr;
  assign o_valid       = r_valid;
  assign o_pred_taken  = r_pred_taken;
  assign o_pred_target = r_pred_target;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, BTB-steered next-PC, mispredict check on ID branches.
// Owns the IF/ID register and a saturating mispredict counter.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic [CNT_W-1:0] r_cnt;

  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_redirect;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_pred_target;
  logic            w_resolve;
  logic            w_mispredict;
  logic            w_bubble;

  assign w_pc_plus4 = r_pc + PC_W'(4);

  assign w_resolve = bus.branch_indicator
                   & bus.if_id_valid
                   & ~bus.stall;

  assign w_mispredict = w_resolve & (
      (bus.branch != bus.if_id_pred_taken) |
      (bus.branch & bus.if_id_pred_taken &
       (bus.pc_branch != bus.if_id_pred_target)));

  // Not-taken recovery restarts right after the branch.
  assign w_redirect = bus.branch ? bus.pc_branch
                                 : bus.if_id_pc + PC_W'(4);

  always_comb begin
    w_pc_next = r_pc;
    if (r_state == BOOT)   w_pc_next = r_pc;
    else if (w_mispredict) w_pc_next = w_redirect;
    else if (bus.stall)    w_pc_next = r_pc;
    else if (bus.bp_taken) w_pc_next = bus.bp_target;
    else                   w_pc_next = w_pc_plus4;
  end

  assign w_pred_target = bus.bp_taken ? bus.bp_target
                                      : w_pc_plus4;
  assign w_bubble = (r_state == BOOT) | w_mispredict;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        BOOT:    r_state <= RUN;
        RUN:     r_state <= RUN;
        default: r_state <= BOOT;
      endcase
      r_pc <= w_pc_next;
      if (w_mispredict && !(&r_cnt))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  if_id_reg u_if_id (
    .clk           (clk),
    .rst           (rst),
    .i_bubble      (w_bubble),
    .i_stall       (bus.stall),
    .i_pc          (r_pc),
    .i_instr       (bus.imem_rdata),
    .i_pred_taken  (bus.bp_taken),
    .i_pred_target (w_pred_target),
    .o_pc          (bus.if_id_pc),
    .o_instr       (bus.if_id_instr),
    .o_valid       (bus.if_id_valid),
    .o_pred_taken  (bus.if_id_pred_taken),
    .o_pred_target (bus.if_id_pred_target)
  );

  assign bus.pc               = r_pc;
  assign bus.imem_addr        = r_pc;
  assign bus.flush            = w_mispredict;
  assign bus.mispredict_count = r_cnt;

endmodule
